// File: rtl/accumulator_unit.sv
// Signed accumulator with load/add/subtract, signed-overflow halt and a
// saturating operation counter. Operands arrive over a valid/ready handshake.
module accumulator_unit #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] operand,
    input  logic                    sub,
    output logic signed [WIDTH-1:0] acc,
    output logic                    acc_valid,
    output logic                    ovf,
    output logic                    halted,
    output logic [CNT_W-1:0]        op_count
);

    typedef enum logic [1:0] {
        EMPTY  = 2'd0,
        ACTIVE = 2'd1,
        HALT   = 2'd2
    } state_t;

    state_t state, state_next;

    logic                    take;
    logic                    do_load;
    logic                    do_update;
    logic                    do_ovf;
    logic signed [WIDTH-1:0] addend;
    logic signed [WIDTH-1:0] sum_p0;
    logic                    ovf_p0;

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Signed overflow: both add-path operands share a sign and the result flips it.
    function automatic logic signed_ovf(input logic a_msb, input logic b_msb,
                                        input logic r_msb);
        return (a_msb == b_msb) && (r_msb != a_msb);
    endfunction

    // Subtraction reuses the adder as acc + ~operand + 1; the most-negative
    // operand goes through the same path and is caught by the overflow rule.
    assign addend   = sub ? ~operand : operand;
    assign sum_p0   = acc + addend + WIDTH'(sub);
    assign ovf_p0   = signed_ovf(acc[WIDTH-1], addend[WIDTH-1], sum_p0[WIDTH-1]);

    // Reset and clear both block acceptance, so neither can race with a transfer.
    assign in_ready = !rst && !clear && (state != HALT);
    assign take     = in_valid && in_ready;
    assign halted   = (state == HALT);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and datapath-control decode.
    always_comb begin
        state_next = state;
        do_load    = 1'b0;
        do_update  = 1'b0;
        do_ovf     = 1'b0;
        if (clear) begin
            state_next = EMPTY;
        end else if (take) begin
            case (state)
                EMPTY: begin
                    do_load    = 1'b1;
                    state_next = ACTIVE;
                end
                ACTIVE: begin
                    if (ovf_p0) begin
                        do_ovf     = 1'b1;
                        state_next = HALT;
                    end else begin
                        do_update  = 1'b1;
                    end
                end
                default: begin
                    state_next = state;
                end
            endcase
        end
    end

    // Accumulator, counter and the one-cycle status pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc       <= '0;
            op_count  <= '0;
            acc_valid <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            acc_valid <= do_load || do_update;
            ovf       <= do_ovf;
            if (clear) begin
                acc      <= '0;
                op_count <= '0;
            end else if (do_load) begin
                acc      <= operand;
                op_count <= '0;
            end else if (do_update) begin
                acc      <= sum_p0;
                op_count <= sat_inc(op_count);
            end
        end
    end

endmodule
